// File: rtl/obstacle_ctrl.sv
// rtl/obstacle_ctrl.sv - sliding obstacle draw/wait/erase/move loop with player crash detection
module obstacle_ctrl #(
  parameter int unsigned OB_W        = 8,
  parameter int unsigned OB_H        = 4,
  parameter int unsigned OB_Y        = 60,
  parameter int unsigned OB_X0       = 0,
  parameter int unsigned STEP        = 1,
  parameter int unsigned X_MAX       = 159,
  parameter int unsigned WAIT_CYCLES = 833333,
  parameter int unsigned P_SIZE      = 4,
  parameter logic [2:0]  OB_COLOUR   = 3'b100
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       go,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic [2:0] current_state_ob,
  output logic       crashing_signal,
  output logic [7:0] pixel_x,
  output logic [6:0] pixel_y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam int unsigned CW = (OB_W > 1) ? $clog2(OB_W) : 1;
  localparam int unsigned RW = (OB_H > 1) ? $clog2(OB_H) : 1;
  localparam int unsigned WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(OB_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(OB_H - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
  localparam logic [9:0]    X_LIMIT   = 10'(X_MAX + 1);
  localparam logic [7:0]    X_START   = 8'(OB_X0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAW  = 3'd2,
    S_WAIT  = 3'd3,
    S_ERASE = 3'd4,
    S_MOVE  = 3'd5,
    S_CHECK = 3'd6,
    S_HALT  = 3'd7
  } state_e;

  state_e        state_q;
  logic [7:0]    ob_x_q;
  logic [7:0]    ob_x_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [WW-1:0] wait_q;
  logic          crash_n_q;
  logic [9:0]    x_step;
  logic [9:0]    x_end;
  logic          overlap;
  logic          last_pix;

  // Wrap test uses the post-step right edge, widened so nothing truncates.
  always_comb begin
    x_step = {2'b00, ob_x_q} + 10'(STEP);
    x_end  = x_step + 10'(OB_W);
    ob_x_d = (x_end > X_LIMIT) ? 8'd0 : x_step[7:0];
  end

  assign overlap = ({1'b0, player_x} < ({1'b0, ob_x_d} + 9'(OB_W)))
                && ({1'b0, ob_x_d} < ({1'b0, player_x} + 9'(P_SIZE)))
                && ({2'b00, player_y} < 9'(OB_Y + OB_H))
                && (9'(OB_Y) < ({2'b00, player_y} + 9'(P_SIZE)));

  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      ob_x_q    <= X_START;
      col_q     <= '0;
      row_q     <= '0;
      wait_q    <= '0;
      crash_n_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (go) state_q <= S_LOAD;
        S_LOAD: begin
          ob_x_q  <= X_START;
          col_q   <= '0;
          row_q   <= '0;
          wait_q  <= '0;
          state_q <= S_DRAW;
        end
        S_DRAW, S_ERASE: begin
          if (last_pix) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= (state_q == S_DRAW) ? S_WAIT : S_MOVE;
          end else if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            wait_q  <= '0;
            state_q <= S_ERASE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        // Crash flag is registered here so it is stable for the whole CHECK cycle.
        S_MOVE: begin
          ob_x_q    <= ob_x_d;
          crash_n_q <= ~overlap;
          state_q   <= S_CHECK;
        end
        S_CHECK: state_q <= crash_n_q ? S_DRAW : S_HALT;
        S_HALT: begin
          if (go) begin
            crash_n_q <= 1'b1;
            ob_x_q    <= X_START;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign current_state_ob = state_q;
  assign crashing_signal  = crash_n_q;
  assign plot             = (state_q == S_DRAW) || (state_q == S_ERASE);
  assign colour           = (state_q == S_DRAW) ? OB_COLOUR : 3'b000;
  assign pixel_x          = ob_x_q + 8'(col_q);
  assign pixel_y          = 7'(OB_Y) + 7'(row_q);

endmodule

// File: tb/tb_obstacle_ctrl.sv
// tb/tb_obstacle_ctrl.sv - trace-model bench for obstacle_ctrl with directed and random phases
module tb_obstacle_ctrl;
  localparam int OB_W = 4, OB_H = 2, OB_Y = 10, X_MAX = 15, STEP = 1, WAITC = 3, P_SIZE = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic [7:0] player_x = 8'd0;
  logic [6:0] player_y = 7'd0;
  logic [2:0] current_state_ob;
  logic       crashing_signal;
  logic [7:0] pixel_x;
  logic [6:0] pixel_y;
  logic [2:0] colour;
  logic       plot;

  obstacle_ctrl #(
    .OB_W(OB_W), .OB_H(OB_H), .OB_Y(OB_Y), .OB_X0(0), .STEP(STEP), .X_MAX(X_MAX),
    .WAIT_CYCLES(WAITC), .P_SIZE(P_SIZE), .OB_COLOUR(3'b100)
  ) dut (
    .CLK(clk), .resetn(resetn), .go(go), .player_x(player_x), .player_y(player_y),
    .current_state_ob(current_state_ob), .crashing_signal(crashing_signal),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output trace: one record per clock cycle, generated a phase at a time.
  typedef struct {
    int st;
    int crash;
    int plot;
    int px;
    int py;
    int col;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int   m_x;
  int   nx;
  bit   hit;
  bit   model_on = 1'b0;

  function automatic rec_t mk(input int st, input int crash, input int pl,
                              input int px, input int py, input int col);
    rec_t r;
    r.st = st; r.crash = crash; r.plot = pl; r.px = px; r.py = py; r.col = col;
    return r;
  endfunction

  task automatic push_loop();
    for (int k = 0; k < OB_W * OB_H; k++) q.push_back(mk(2, 1, 1, m_x + k % OB_W, OB_Y + k / OB_W, 4));
    for (int i = 0; i < WAITC; i++) q.push_back(mk(3, 1, 0, 0, 0, 0));
    for (int k = 0; k < OB_W * OB_H; k++) q.push_back(mk(4, 1, 1, m_x + k % OB_W, OB_Y + k / OB_W, 0));
    q.push_back(mk(5, 1, 0, 0, 0, 0));
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      q.delete();
      m_x = 0;
      cur = mk(0, 1, 0, 0, 0, 0);
      model_on = 1'b1;
    end else if (model_on) begin
      if (q.size() == 0) begin
        case (cur.st)
          0: if (go) q.push_back(mk(1, 1, 0, 0, 0, 0)); else q.push_back(cur);
          1: begin m_x = 0; push_loop(); end
          5: begin
            nx = m_x + STEP;
            if (nx + OB_W > X_MAX + 1) nx = 0;
            m_x = nx;
            hit = (int'(player_x) < m_x + OB_W) && (m_x < int'(player_x) + P_SIZE)
               && (int'(player_y) < OB_Y + OB_H) && (OB_Y < int'(player_y) + P_SIZE);
            q.push_back(mk(6, hit ? 0 : 1, 0, 0, 0, 0));
          end
          6: if (cur.crash == 0) q.push_back(mk(7, 0, 0, 0, 0, 0)); else push_loop();
          7: if (go) q.push_back(mk(0, 1, 0, 0, 0, 0)); else q.push_back(cur);
          default: q.push_back(mk(0, 1, 0, 0, 0, 0));
        endcase
      end
      cur = q.pop_front();
    end
  end

  int draw_x[$];
  int prev_st = -1;

  always @(negedge clk) begin
    if (model_on) begin
      chk("state", current_state_ob, cur.st);
      chk("crash", crashing_signal, cur.crash);
      chk("plot", plot, cur.plot);
      if (cur.plot != 0) begin
        chk("pixel_x", pixel_x, cur.px);
        chk("pixel_y", pixel_y, cur.py);
        chk("colour", colour, cur.col);
      end
      if (current_state_ob == 3'd2 && prev_st != 2) draw_x.push_back(int'(pixel_x));
      prev_st = int'(current_state_ob);
    end
  end

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (current_state_ob !== 3'(s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state_timeout", current_state_ob, s);
  endtask

  task automatic wait_draws(input int cnt, input int budget);
    int n = 0;
    while (draw_x.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_draws_timeout", draw_x.size() >= cnt, 1);
  endtask

  int px_tab[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int py_tab[8] = '{10, 10, 10, 10, 11, 11, 11, 11};
  int base;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; go = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", current_state_ob, 0);
    chk("rst_crash", crashing_signal, 1);
    chk("rst_plot", plot, 0);
    resetn = 1'b1; go = 1'b0;

    @(negedge clk);
    chk("idle_hold", current_state_ob, 0);
    go = 1'b1;
    @(negedge clk);
    chk("load", current_state_ob, 1);
    go = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("draw_state", current_state_ob, 2);
      chk("draw_px", pixel_x, px_tab[k]);
      chk("draw_py", pixel_y, py_tab[k]);
      chk("draw_colour", colour, 3'b100);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_state", current_state_ob, 3);
      chk("wait_plot", plot, 0);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("erase_state", current_state_ob, 4);
      chk("erase_px", pixel_x, px_tab[k]);
      chk("erase_py", pixel_y, py_tab[k]);
      chk("erase_colour", colour, 0);
    end
    @(negedge clk);
    chk("move_state", current_state_ob, 5);
    @(negedge clk);
    chk("check_state", current_state_ob, 6);
    chk("check_crash", crashing_signal, 1);
    @(negedge clk);
    chk("redraw_state", current_state_ob, 2);
    chk("redraw_px", pixel_x, 1);

    wait_draws(14, 400);
    chk("wrap_x11", draw_x[11], 11);
    chk("wrap_x12", draw_x[12], 12);
    chk("wrap_x0", draw_x[13], 0);

    wait_draws(18, 200);
    chk("crash_pre_x", draw_x[17], 4);
    player_x = 8'd5; player_y = 7'd10;
    wait_state(6, 60);
    chk("crash_flag", crashing_signal, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_state", current_state_ob, 7);
      chk("halt_crash", crashing_signal, 0);
      chk("halt_plot", plot, 0);
    end
    go = 1'b1;
    @(negedge clk);
    chk("restart_state", current_state_ob, 0);
    chk("restart_crash", crashing_signal, 1);
    go = 1'b0;
    player_x = 8'd0; player_y = 7'd0;

    base = draw_x.size();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_draws(base + 5, 200);
    chk("edge_pre_x", draw_x[base + 4], 4);
    player_x = 8'd9; player_y = 7'd10;
    wait_state(6, 60);
    chk("edge_crash", crashing_signal, 1);
    @(negedge clk);
    chk("edge_redraw", current_state_ob, 2);
    chk("edge_px", pixel_x, 5);
    player_x = 8'd0; player_y = 7'd0;

    repeat (3) @(negedge clk);
    chk("mid_k3_px", pixel_x, 8);
    resetn = 1'b0; go = 1'b1;
    @(negedge clk);
    chk("midrst_state", current_state_ob, 0);
    chk("midrst_plot", plot, 0);
    chk("midrst_crash", crashing_signal, 1);
    resetn = 1'b1; go = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_idle", current_state_ob, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      go = ($urandom_range(0, 7) == 0);
      resetn = ($urandom_range(0, 299) != 0);
      player_x = 8'($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) player_y = 7'($urandom_range(8, 12));
      else player_y = 7'($urandom_range(0, 127));
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
